// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared types and constants for the read-only SPI master.
//   spi_state_t  : controller state encoding (IDLE, SETUP, SHIFT, GAP)
//   DEF_CLK_DIV  : default clk cycles per SCLK half-period
//   DEF_NBITS    : default frame length in bits
//   frame_cycles : clk edges from the edge that samples spi_ena up to and
//                  including the edge that raises spi_not_busy again
// -----------------------------------------------------------------------------
package spi_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      SHIFT = 2'd2,
      GAP   = 2'd3
   } spi_state_t;

   localparam int DEF_CLK_DIV = 4;
   localparam int DEF_NBITS   = 32;

   // SETUP + SHIFT + GAP occupy CLK_DIV*(2*NBITS+2) cycles; the extra one is
   // the IDLE edge that accepts the request.
   function automatic int frame_cycles(input int clk_div, input int nbits);
      return clk_div * (2 * nbits + 2) + 1;
   endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// -----------------------------------------------------------------------------
// spi_tick_gen
// Free-running modulo-CLK_DIV counter that paces the SPI phases.
// Ports:
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   clr   : synchronous clear, holds the count at zero
//   tick  : high in the last cycle of each CLK_DIV-cycle period (wrap cycle)
// -----------------------------------------------------------------------------
module spi_tick_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic tick
);

   localparam int CW = $clog2(CLK_DIV) + 1;

   logic [CW-1:0] cnt;

   assign tick = (cnt == CW'(CLK_DIV - 1));

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours, independent of block order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/spi_rx_master.sv
// -----------------------------------------------------------------------------
// spi_rx_master
// Read-only SPI master, CPOL=0 / CPHA=0, MSB first. On a spi_ena request it
// asserts cs_n, waits one half-period, clocks NBITS bits in on rising SCLK,
// publishes the frame and holds cs_n high for one half-period before idling.
// Ports:
//   clk          : system clock, all logic on posedge
//   rst_n        : synchronous active-low reset, aborts any transfer
//   spi_ena      : transfer request, level-sensitive, only looked at in IDLE
//   miso         : serial data from the converter
//   sclk         : SPI clock, idle low
//   cs_n         : chip select, active low
//   spi_not_busy : high only while IDLE
//   spi_rx_data  : last completed frame, MSB = first bit received
//   rx_valid     : one-cycle pulse when spi_rx_data updates
// -----------------------------------------------------------------------------
module spi_rx_master
   import spi_pkg::*;
#(
   parameter int CLK_DIV = DEF_CLK_DIV,
   parameter int NBITS   = DEF_NBITS
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             spi_ena,
   input  logic             miso,
   output logic             sclk,
   output logic             cs_n,
   output logic             spi_not_busy,
   output logic [NBITS-1:0] spi_rx_data,
   output logic             rx_valid
);

   localparam int BW = $clog2(NBITS) + 1;

   spi_state_t       state, state_nxt;
   logic             tick;
   logic [BW-1:0]    bit_cnt, bit_cnt_nxt;
   logic [NBITS-1:0] shreg;
   logic             sclk_nxt, cs_n_nxt, not_busy_nxt, rx_valid_nxt;
   logic             shift_en, load_en;

   // The divider is parked at zero in IDLE, so each phase starts a fresh
   // CLK_DIV period; phase transitions coincide with its wrap.
   spi_tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (state == IDLE),
      .tick  (tick)
   );

   // NOTE: every signal written here gets a default first, so no path through
   // the case leaves a value unassigned and no latch is inferred.
   always_comb begin
      state_nxt    = state;
      sclk_nxt     = sclk;
      cs_n_nxt     = cs_n;
      not_busy_nxt = spi_not_busy;
      rx_valid_nxt = 1'b0;
      bit_cnt_nxt  = bit_cnt;
      shift_en     = 1'b0;
      load_en      = 1'b0;

      case (state)
         IDLE: begin
            sclk_nxt     = 1'b0;
            cs_n_nxt     = 1'b1;
            not_busy_nxt = 1'b1;
            if (spi_ena) begin
               state_nxt    = SETUP;
               cs_n_nxt     = 1'b0;
               not_busy_nxt = 1'b0;
            end
         end

         SETUP: begin
            if (tick) begin
               state_nxt   = SHIFT;
               bit_cnt_nxt = '0;
            end
         end

         SHIFT: begin
            if (tick) begin
               if (!sclk) begin
                  // Rising edge: sample miso as seen at this clk edge.
                  sclk_nxt    = 1'b1;
                  shift_en    = 1'b1;
                  bit_cnt_nxt = bit_cnt + BW'(1);
               end else if (bit_cnt == BW'(NBITS)) begin
                  // Falling edge after the last rise closes the frame.
                  sclk_nxt     = 1'b0;
                  load_en      = 1'b1;
                  rx_valid_nxt = 1'b1;
                  cs_n_nxt     = 1'b1;
                  state_nxt    = GAP;
               end else begin
                  sclk_nxt = 1'b0;
               end
            end
         end

         GAP: begin
            if (tick) begin
               state_nxt    = IDLE;
               not_busy_nxt = 1'b1;
            end
         end

         default: begin
            state_nxt    = IDLE;
            sclk_nxt     = 1'b0;
            cs_n_nxt     = 1'b1;
            not_busy_nxt = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         sclk         <= 1'b0;
         cs_n         <= 1'b1;
         spi_not_busy <= 1'b1;
         rx_valid     <= 1'b0;
         bit_cnt      <= '0;
         shreg        <= '0;
         spi_rx_data  <= '0;
      end else begin
         state        <= state_nxt;
         sclk         <= sclk_nxt;
         cs_n         <= cs_n_nxt;
         spi_not_busy <= not_busy_nxt;
         rx_valid     <= rx_valid_nxt;
         bit_cnt      <= bit_cnt_nxt;
         // Shift written without a slice so NBITS=1 stays legal.
         if (shift_en) begin
            shreg <= (shreg << 1) | NBITS'(miso);
         end
         if (load_en) begin
            spi_rx_data <= shreg;
         end
      end
   end

endmodule

// File: tb/tb_spi_rx_master.sv
// -----------------------------------------------------------------------------
// tb_spi_rx_master
// Directed bench for spi_rx_master: a default instance (CLK_DIV=4, NBITS=32)
// and a minimum-divider instance (CLK_DIV=1, NBITS=8), each driven by a
// behavioural converter that shifts MSB first on the SCLK falling edge.
// -----------------------------------------------------------------------------
module tb_spi_rx_master;
   import spi_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;

   // Default instance
   logic        spi_ena_d, miso_d, sclk_d, cs_n_d, nb_d, rv_d;
   logic [31:0] rx_d;
   logic [31:0] sd_frame;
   int          sd_idx;

   // Small instance
   logic        spi_ena_s, miso_s, sclk_s, cs_n_s, nb_s, rv_s;
   logic [7:0]  rx_s;
   logic [7:0]  ss_frame;
   int          ss_idx;

   // cs_n high-run monitor for the default instance
   int          hi_run = 0;
   int          last_gap = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   spi_rx_master dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .spi_ena      (spi_ena_d),
      .miso         (miso_d),
      .sclk         (sclk_d),
      .cs_n         (cs_n_d),
      .spi_not_busy (nb_d),
      .spi_rx_data  (rx_d),
      .rx_valid     (rv_d)
   );

   spi_rx_master #(
      .CLK_DIV (1),
      .NBITS   (8)
   ) dut_s (
      .clk          (clk),
      .rst_n        (rst_n),
      .spi_ena      (spi_ena_s),
      .miso         (miso_s),
      .sclk         (sclk_s),
      .cs_n         (cs_n_s),
      .spi_not_busy (nb_s),
      .spi_rx_data  (rx_s),
      .rx_valid     (rv_s)
   );

   // Converter models: first bit presented when cs_n falls, next bit on each
   // SCLK fall.
   always @(negedge cs_n_d) begin
      sd_idx = 31;
      miso_d = sd_frame[sd_idx];
   end
   always @(negedge sclk_d) begin
      if (!cs_n_d && sd_idx > 0) begin
         sd_idx = sd_idx - 1;
         miso_d = sd_frame[sd_idx];
      end
   end

   always @(negedge cs_n_s) begin
      ss_idx = 7;
      miso_s = ss_frame[ss_idx];
   end
   always @(negedge sclk_s) begin
      if (!cs_n_s && ss_idx > 0) begin
         ss_idx = ss_idx - 1;
         miso_s = ss_frame[ss_idx];
      end
   end

   always @(negedge clk) begin
      if (cs_n_d === 1'b1) begin
         hi_run = hi_run + 1;
      end else begin
         if (hi_run > 0) last_gap = hi_run;
         hi_run = 0;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Runs one frame on the default instance, sampling on falling clk edges.
   // Returns when spi_not_busy is seen high again after having been low.
   task automatic run_frame_d(input logic [31:0] pattern, input bit hold,
                              output int cs_low, output int rises, output int nb_low,
                              output int rv_cnt, output int rv_cyc, output bit first_busy);
      bit seen = 1'b0;
      bit prev = sclk_d;
      sd_frame   = pattern;
      spi_ena_d  = 1'b1;
      cs_low     = 0;
      rises      = 0;
      nb_low     = 0;
      rv_cnt     = 0;
      rv_cyc     = 0;
      first_busy = 1'b0;
      for (int n = 0; n < 1000; n++) begin
         @(negedge clk);
         if (n == 0) first_busy = !nb_d;
         if (!nb_d) begin
            seen = 1'b1;
            if (!hold) spi_ena_d = 1'b0;
            nb_low++;
         end
         if (!cs_n_d) cs_low++;
         if (sclk_d && !prev) rises++;
         prev = sclk_d;
         if (rv_d) begin
            rv_cnt++;
            rv_cyc = cyc;
         end
         if (seen && nb_d) break;
      end
      check("frame_done", {63'd0, seen && nb_d}, 64'd1);
   endtask

   int cs_low, rises, nb_low, rv_cnt, rv_cyc1, rv_cyc2, r1, r2, rv_seen;
   bit first_busy, seen_s, prev_s;
   logic [31:0] data1;

   initial begin
      rst_n     = 1'b0;
      spi_ena_d = 1'b1;
      spi_ena_s = 1'b0;
      miso_d    = 1'b0;
      miso_s    = 1'b0;
      sd_frame  = 32'hA5C3_0F81;
      ss_frame  = 8'h00;

      // ---- Reset held 3 cycles with a pending request ----
      repeat (3) @(negedge clk);
      check("rst_sclk",     {63'd0, sclk_d}, 64'd0);
      check("rst_cs_n",     {63'd0, cs_n_d}, 64'd1);
      check("rst_not_busy", {63'd0, nb_d},   64'd1);
      check("rst_rx_data",  {32'd0, rx_d},   64'd0);
      check("rst_rx_valid", {63'd0, rv_d},   64'd0);
      check("rst_s_cs_n",   {63'd0, cs_n_s}, 64'd1);
      check("rst_s_rx",     {56'd0, rx_s},   64'd0);

      // ---- Release: first frame starts on the next edge ----
      rst_n = 1'b1;
      run_frame_d(32'hA5C3_0F81, 1'b0, cs_low, rises, nb_low, rv_cnt, rv_cyc1, first_busy);
      check("single_busy_next_edge", {63'd0, first_busy}, 64'd1);
      check("single_data",   {32'd0, rx_d}, 64'h0000_0000_A5C3_0F81);
      check("single_rv_cnt", 64'(rv_cnt), 64'd1);
      check("single_rises",  64'(rises),  64'd32);
      check("single_cs_low", 64'(cs_low), 64'd260);
      // low samples plus the edge that accepted spi_ena
      check("single_period", 64'(nb_low + 1), 64'(frame_cycles(DEF_CLK_DIV, DEF_NBITS)));
      repeat (20) @(negedge clk);
      check("single_hold", {32'd0, rx_d}, 64'h0000_0000_A5C3_0F81);

      // ---- Back-to-back with spi_ena held high ----
      run_frame_d(32'hFFFF_FFFF, 1'b1, cs_low, rises, nb_low, rv_cnt, rv_cyc1, first_busy);
      data1 = rx_d;
      check("b2b_data1",   {32'd0, data1}, 64'h0000_0000_FFFF_FFFF);
      check("b2b_rv_cnt1", 64'(rv_cnt), 64'd1);
      run_frame_d(32'h0000_0001, 1'b1, cs_low, rises, nb_low, rv_cnt, rv_cyc2, first_busy);
      spi_ena_d = 1'b0;
      check("b2b_start2",  {63'd0, first_busy}, 64'd1);
      check("b2b_data2",   {32'd0, rx_d}, 64'h0000_0000_0000_0001);
      check("b2b_rv_cnt2", 64'(rv_cnt), 64'd1);
      check("b2b_rv_spacing", 64'(rv_cyc2 - rv_cyc1), 64'd265);
      check("b2b_cs_gap",  64'(last_gap), 64'(DEF_CLK_DIV + 1));
      repeat (10) @(negedge clk);
      check("b2b_idle", {63'd0, nb_d}, 64'd1);

      // ---- Abort by reset after the 10th SCLK rise ----
      sd_frame  = 32'h1234_5678;
      spi_ena_d = 1'b1;
      rises     = 0;
      prev_s    = sclk_d;
      for (int n = 0; n < 1000; n++) begin
         @(negedge clk);
         if (!nb_d) spi_ena_d = 1'b0;
         if (sclk_d && !prev_s) rises++;
         prev_s = sclk_d;
         if (rises == 10) break;
      end
      check("abort_reach10", 64'(rises), 64'd10);
      rst_n = 1'b0;
      @(negedge clk);
      check("abort_cs_n",     {63'd0, cs_n_d}, 64'd1);
      check("abort_sclk",     {63'd0, sclk_d}, 64'd0);
      check("abort_rx_data",  {32'd0, rx_d},   64'd0);
      check("abort_not_busy", {63'd0, nb_d},   64'd1);
      rst_n   = 1'b1;
      rv_seen = 0;
      repeat (300) begin
         @(negedge clk);
         if (rv_d) rv_seen++;
      end
      check("abort_no_valid", 64'(rv_seen), 64'd0);
      check("abort_data_0",   {32'd0, rx_d}, 64'd0);

      // ---- Divider extreme: CLK_DIV=1, NBITS=8 ----
      ss_frame  = 8'h5A;
      spi_ena_s = 1'b1;
      seen_s = 1'b0; prev_s = sclk_s;
      cs_low = 0; rises = 0; nb_low = 0; rv_cnt = 0; r1 = 0; r2 = 0;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (!nb_s) begin
            seen_s = 1'b1;
            spi_ena_s = 1'b0;
            nb_low++;
         end
         if (!cs_n_s) cs_low++;
         if (sclk_s && !prev_s) begin
            rises++;
            if (rises == 1) r1 = cyc;
            if (rises == 2) r2 = cyc;
         end
         prev_s = sclk_s;
         if (rv_s) rv_cnt++;
         if (seen_s && nb_s) break;
      end
      check("small_done",   {63'd0, seen_s && nb_s}, 64'd1);
      check("small_data",   {56'd0, rx_s}, 64'h5A);
      check("small_rv_cnt", 64'(rv_cnt), 64'd1);
      check("small_rises",  64'(rises),  64'd8);
      check("small_period", 64'(r2 - r1), 64'd2);
      check("small_cs_low", 64'(cs_low), 64'd17);
      check("small_frame",  64'(nb_low + 1), 64'(frame_cycles(1, 8)));

      // ---- Decoder handshake: request dropped once busy is seen ----
      run_frame_d(32'h0640_1900, 1'b0, cs_low, rises, nb_low, rv_cnt, rv_cyc1, first_busy);
      check("dec_busy_fall",   {63'd0, first_busy}, 64'd1);
      check("dec_rv_cnt",      64'(rv_cnt), 64'd1);
      check("dec_tc_temp",     {50'd0, rx_d[31:18]}, 64'h0190);
      check("dec_junction",    {52'd0, rx_d[15:4]},  64'h190);
      check("dec_fault_bits",  {60'd0, rx_d[16], rx_d[2:0]}, 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
